// File: rtl/hex_display_scanner_pkg.sv
// Shared types for the multiplexed 7-segment scanner: nibble and segment vectors,
// scan state and the all-off segment pattern.
package hex_display_pkg;
    typedef logic [3:0] nibble_t;
    typedef logic [0:6] seg_t;              // index 0 = segment a
    typedef enum logic {SHOW, BLANK} scan_state_t;
    localparam seg_t SEG_OFF = 7'b0000000;
endpackage

// File: rtl/hex_display_scanner_if.sv
// Nibble write port of the display scanner: valid/ready with target digit and value.
interface hex_display_scanner_if #(parameter int DIGITS = 4);
    import hex_display_pkg::*;
    localparam int IW = $clog2(DIGITS);

    logic           wr_valid;
    logic           wr_ready;
    logic [IW-1:0]  wr_index;
    nibble_t        wr_value;

    modport master (output wr_valid, output wr_index, output wr_value, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_index, input  wr_value, output wr_ready);
endinterface

// File: rtl/hex_display_scanner_hex_decoder.sv
// Hex nibble to active-high 7-segment pattern (a..g, a at index 0).
module hex_decoder
    import hex_display_pkg::*;
(
    input  nibble_t value,
    output seg_t    seg
);
    always_comb begin
        seg = SEG_OFF;
        unique case (value)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
        endcase
    end
endmodule

// File: rtl/hex_display_scanner.sv
// Scans DIGITS nibble registers onto one 7-segment bus with a blanking gap between digits.
// Optional leading-zero suppression: define HEX_DISPLAY_LEADING_ZERO_BLANK_EN.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SHOW_CYC  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hex_display_scanner_if.slave  wr,
    output seg_t                  segments,
    output logic [DIGITS-1:0]     digit_en
);
    localparam int IW   = $clog2(DIGITS);
    localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] SEL_LAST   = IW'(DIGITS - 1);
    localparam logic [IW:0]   DIG_N      = (IW+1)'(DIGITS);

    nibble_t         regs [DIGITS];
    scan_state_t     state;
    logic [IW-1:0]   sel;
    logic [CW-1:0]   cnt;
    seg_t            dec_seg;
    seg_t            show_seg;
    logic            wr_fire;
    logic            wr_in_range;

    hex_decoder u_dec (.value(regs[sel]), .seg(dec_seg));

    // The lit digit's register is locked; every other digit (or any digit during BLANK) is writable.
    assign wr.wr_ready  = (state == BLANK) || (wr.wr_index != sel);
    assign wr_fire      = wr.wr_valid && wr.wr_ready;
    assign wr_in_range  = ({1'b0, wr.wr_index} < DIG_N);

`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz;
    logic              run;
    // lz[i]: digit i and every digit above it hold zero; digit 0 never blanks.
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int i = DIGITS-1; i >= 0; i--) begin
            run   = run && (regs[i] == 4'h0);
            lz[i] = run;
        end
        lz[0] = 1'b0;
    end
    assign show_seg = lz[sel] ? SEG_OFF : dec_seg;
`else
    assign show_seg = dec_seg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SHOW;
            cnt      <= '0;
            sel      <= '0;
            segments <= SEG_OFF;
            digit_en <= '0;
            for (int i = 0; i < DIGITS; i++) regs[i] <= '0;
        end else begin
            case (state)
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt   <= '0;
                        state <= BLANK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= SHOW;
                        sel   <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase

            // Outputs trail the scan state by one cycle.
            if (state == SHOW) begin
                digit_en <= {{(DIGITS-1){1'b0}}, 1'b1} << sel;
                segments <= show_seg;
            end else begin
                digit_en <= '0;
                segments <= SEG_OFF;
            end

            if (wr_fire && wr_in_range) regs[wr.wr_index] <= wr.wr_value;
        end
    end
endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with DIGITS=4, SHOW_CYC=4, BLANK_CYC=2.
module tb_hex_display_scanner;
    import hex_display_pkg::*;

    localparam int DIGITS    = 4;
    localparam int SHOW_CYC  = 4;
    localparam int BLANK_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    seg_t        segments;
    logic [3:0]  digit_en;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          w;

    hex_display_scanner_if #(.DIGITS(DIGITS)) wr_if ();

    hex_display_scanner #(
        .DIGITS(DIGITS), .SHOW_CYC(SHOW_CYC), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr_if.slave), .segments(segments), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one write and hold it until accepted; returns cycles spent stalled.
    task automatic wr(input logic [1:0] idx, input logic [3:0] val, output int waited);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_index = idx;
        wr_if.wr_value = val;
        waited = 0;
        #1;
        while (!wr_if.wr_ready && waited < 50) begin
            step();
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    // Advance to the first lit cycle of the digit whose enable is en.
    task automatic wait_lit(input logic [3:0] en, input string tag);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            prev = digit_en;
            step();
            if (digit_en == en && prev != en) found = 1'b1;
        end
        check({tag, "_sync"}, 32'(found), 32'd1);
    endtask

    logic [6:0] exp_tab [4];

    initial begin
        exp_tab[0] = 7'b0110000;
        exp_tab[1] = 7'b1101101;
        exp_tab[2] = 7'b1111001;
        exp_tab[3] = 7'b0110011;
        rst = 1'b1;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_index = '0;
        wr_if.wr_value = '0;

        // Reset and first lit cycle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold_en", 32'(digit_en), 32'h0);
        rst = 1'b0;
        #1;
        check("rst_c1_en",  32'(digit_en), 32'h0);
        check("rst_c1_seg", 32'(segments), 32'h0);
        step();
        check("rst_c2_en",  32'(digit_en), 32'b0001);
        check("rst_c2_seg", 32'(segments), 32'(7'b1111110));

        // Scan order over a full frame plus the wrap back to digit 0
        wr(2'd1, 4'h2, w); check("wr1_nostall", 32'(w), 32'd0);
        wr(2'd2, 4'h3, w); check("wr2_nostall", 32'(w), 32'd0);
        wr(2'd3, 4'h4, w); check("wr3_nostall", 32'(w), 32'd0);
        wr(2'd0, 4'h1, w); check("wr0_accept",  32'(w < 50), 32'd1);
        wait_lit(4'b0001, "frame");
        for (int c = 0; c < 25; c++) begin
            int  d;
            logic lit;
            d   = (c / 6) % 4;
            lit = (c % 6) < 4;
            check($sformatf("frame_en%0d", c),  32'(digit_en), lit ? 32'(1 << d) : 32'h0);
            check($sformatf("frame_seg%0d", c), 32'(segments), lit ? 32'(exp_tab[d]) : 32'h0);
            if (c < 24) step();
        end

        // Stall while the target digit is lit
        wait_lit(4'b0100, "stall");
        wr_if.wr_index = 2'd2;
        #1;
        check("ready_novalid", 32'(wr_if.wr_ready), 32'd0);
        wr(2'd2, 4'hF, w);
        check("stall_cycles", 32'(w), 32'd3);
        wait_lit(4'b0100, "stall_show");
        check("stall_seg", 32'(segments), 32'(7'b1000111));

        // Concurrent write to a dark digit
        wait_lit(4'b0001, "conc");
        wr(2'd1, 4'hA, w);
        check("conc_nostall", 32'(w), 32'd0);
        wait_lit(4'b0010, "conc_show");
        check("conc_seg", 32'(segments), 32'(7'b1110111));

        // Write in the last BLANK cycle to the digit about to be selected
        repeat (4) step();
        wr(2'd2, 4'h7, w);
        check("edge_nostall", 32'(w), 32'd0);
        check("edge_dark",    32'(digit_en), 32'h0);
        step();
        check("edge_en",  32'(digit_en), 32'b0100);
        check("edge_seg", 32'(segments), 32'(7'b1110000));

        // Asynchronous reset mid-SHOW loses stored digits
        wr(2'd3, 4'h8, w);
        check("d3_nostall", 32'(w), 32'd0);
        wait_lit(4'b1000, "pre_rst");
        check("pre_rst_seg", 32'(segments), 32'(7'b1111111));
        step();
        rst = 1'b1;
        #1;
        check("rst_mid_en",  32'(digit_en), 32'h0);
        check("rst_mid_seg", 32'(segments), 32'h0);
        step();
        rst = 1'b0;
        wait_lit(4'b1000, "post_rst");
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
        check("post_rst_seg", 32'(segments), 32'h0);
`else
        check("post_rst_seg", 32'(segments), 32'(7'b1111110));
`endif

        // {d3..d0} = {0,5,0,0}: only d3 is a leading zero
        wr(2'd2, 4'h5, w);
        check("lz_wr", 32'(w), 32'd0);
        wait_lit(4'b1000, "lz_d3");
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
        check("lz_d3_seg", 32'(segments), 32'h0);
`else
        check("lz_d3_seg", 32'(segments), 32'(7'b1111110));
`endif
        wait_lit(4'b0001, "lz_d0");
        check("lz_d0_seg", 32'(segments), 32'(7'b1111110));
        wait_lit(4'b0010, "lz_d1");
        check("lz_d1_seg", 32'(segments), 32'(7'b1111110));
        wait_lit(4'b0100, "lz_d2");
        check("lz_d2_seg", 32'(segments), 32'(7'b1011011));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
